// File: rtl/vecscale_pivot_pkg.sv
// Shared fixed-point helpers and FSM state encoding for the pivot normaliser.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package vecscale_pivot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECIP = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to hold the values 0..n (minimum one bit).
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_width(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/vecscale_pivot_fixrecip.sv
// Serial restoring reciprocal r = min(floor(2^(2*SCALE)/mag), 2^(WIDTH-1)-1); mag==0 gives r=0, div0=1.
// Latency: start pulse loads, then 2*SCALE+1 quotient-bit cycles; done pulses for one cycle after the last.
// Backpressure: none; a start while busy restarts the divide. r/div0 hold until the next completion.
module fixrecip_serial
    import vecscale_pivot_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SCALE = 8
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             start,
    input  logic [WIDTH-1:0] mag,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             div0
);
    localparam int          DIV_CYC = 2 * SCALE + 1;
    localparam int          CW      = idx_w(DIV_CYC - 1);
    localparam logic [63:0] RMAX    = (64'd1 << (WIDTH - 1)) - 64'd1;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    den_q, den_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [DIV_CYC-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]    r_q, r_d;
    logic                div0_q, div0_d;

    logic [WIDTH:0]      trial;
    logic                take;
    logic [DIV_CYC-1:0]  quo_nxt;

    // One restoring step per cycle; the dividend 2^(2*SCALE) is a single 1 followed by zeros.
    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        den_d   = den_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        r_d     = r_q;
        div0_d  = div0_q;
        trial   = {rem_q, (cnt_q == '0)};
        take    = (trial >= {1'b0, den_q});
        quo_nxt = DIV_CYC'({quo_q, take});
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            den_d  = mag;
            rem_d  = '0;
            quo_d  = '0;
        end else if (busy_q) begin
            rem_d = take ? WIDTH'(trial - {1'b0, den_q}) : WIDTH'(trial);
            quo_d = quo_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DIV_CYC - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                div0_d = (den_q == '0);
                if (den_q == '0)
                    r_d = '0;
                else if (64'(quo_nxt) > RMAX)
                    r_d = WIDTH'(RMAX);
                else
                    r_d = WIDTH'(quo_nxt);
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            r_q    <= '0;
            div0_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            den_q  <= den_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            r_q    <= r_d;
            div0_q <= div0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign r    = r_q;
    assign div0 = div0_q;

endmodule

// File: rtl/vecscale_pivot.sv
// Normalises a vector by its pivot: f[i] = sat((a[i]*(1/p)) >>> SCALE), sign-corrected for p<0.
// Latency: out_valid rises 2*SCALE+1+COLS+1 cycles after the accept edge; one vector in flight.
// Backpressure: in_ready only in IDLE; f/div0/out_valid hold in DONE until out_ready.
module vecscale_pivot
    import vecscale_pivot_pkg::*;
#(
    parameter int COLS  = 1,
    parameter int WIDTH = 16,
    parameter int SCALE = 8
) (
    input  logic                         clk,
    input  logic                         reset_l,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [COLS:1][WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]      p,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COLS:1][WIDTH-1:0]     f,
    output logic                         div0
);
    localparam int IW = idx_w(COLS);
    localparam int W2 = 2 * WIDTH;

    state_t                      state_q, state_d;
    logic [COLS:1][WIDTH-1:0]    a_q, a_d;
    logic                        neg_q, neg_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [COLS:1][WIDTH-1:0]    f_q, f_d;
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;

    logic                        rc_start;
    logic [WIDTH-1:0]            mag;
    logic                        rc_busy;
    logic                        rc_done;
    logic [WIDTH-1:0]            rc_r;
    logic                        rc_div0;

    logic signed [W2-1:0]        prod;
    logic signed [W2-1:0]        shifted;
    logic signed [63:0]          wide;
    logic [WIDTH-1:0]            scaled;

    // |p| as an unsigned magnitude, so the most-negative pivot maps cleanly to 2^(WIDTH-1).
    assign mag = p[WIDTH-1] ? $unsigned(-p) : $unsigned(p);

    fixrecip_serial #(.WIDTH(WIDTH), .SCALE(SCALE)) u_recip (
        .clk     (clk),
        .reset_l (reset_l),
        .start   (rc_start),
        .mag     (mag),
        .busy    (rc_busy),
        .done    (rc_done),
        .r       (rc_r),
        .div0    (rc_div0)
    );

    // Scale the current element by the reciprocal, floor-shift, fix the sign, then saturate.
    always_comb begin
        prod    = W2'($signed(a_q[idx_q])) * W2'($signed(rc_r));
        shifted = prod >>> SCALE;
        wide    = 64'(shifted);
        if (neg_q)
            wide = -wide;
        scaled  = WIDTH'(sat_width(wide, WIDTH));
    end

    // Control FSM next state: accept, wait for reciprocal, walk elements, hold result.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        neg_d       = neg_q;
        idx_d       = idx_q;
        f_d         = f_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        rc_start    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d    = ST_RECIP;
                    a_d        = a;
                    neg_d      = p[WIDTH-1];
                    idx_d      = IW'(1);
                    in_ready_d = 1'b0;
                    rc_start   = 1'b1;
                end
            end
            ST_RECIP: begin
                if (rc_done && !rc_busy)
                    state_d = ST_SCALE;
            end
            ST_SCALE: begin
                f_d[idx_q] = scaled;
                if (idx_q == IW'(COLS)) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers; reset aborts any vector in flight and clears f.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            neg_q       <= 1'b0;
            idx_q       <= IW'(1);
            f_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            neg_q       <= neg_d;
            idx_q       <= idx_d;
            f_q         <= f_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign div0      = rc_div0;

endmodule

// File: tb/tb_vecscale_pivot.sv
// Bench for vecscale_pivot with WIDTH=16, SCALE=8, COLS=3: directed, backpressure, reset and random vectors.
// Expected results come from fixed tables and an arithmetic reference model.
// Sampling happens on the falling clock edge; inputs change after the rising edge or on the falling edge.
module tb_vecscale_pivot;
    localparam int W   = 16;
    localparam int SC  = 8;
    localparam int N   = 3;
    localparam int LAT = 2 * SC + 1 + N + 1;

    typedef logic [N:1][W-1:0] vec_t;

    logic                clk = 1'b0;
    logic                reset_l = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    vec_t                a_i = '0;
    logic signed [W-1:0] p_i = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    vec_t                f;
    logic                div0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vecscale_pivot #(.COLS(N), .WIDTH(W), .SCALE(SC)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .p         (p_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .div0      (div0)
    );

    function automatic vec_t mk(input int e1, input int e2, input int e3);
        vec_t v;
        v[1] = W'(e1);
        v[2] = W'(e2);
        v[3] = W'(e3);
        return v;
    endfunction

    // Reference: reciprocal by integer division, then plain signed arithmetic per element.
    function automatic void model(input vec_t av, input logic signed [W-1:0] pv,
                                  output vec_t fv, output logic d0);
        longint mag, r, v;
        d0  = (pv == 0);
        mag = (pv < 0) ? -longint'(pv) : longint'(pv);
        if (d0) begin
            r = 0;
        end else begin
            r = (longint'(1) << (2 * SC)) / mag;
            if (r > 32767) r = 32767;
        end
        for (int i = 1; i <= N; i++) begin
            v = longint'($signed(av[i])) * r;
            v = v >>> SC;
            if (pv < 0) v = -v;
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            fv[i] = v[W-1:0];
        end
    endfunction

    // Present a vector, wait for acceptance, then count cycles until out_valid.
    task automatic send_wait(input vec_t av, input logic signed [W-1:0] pv,
                             output int lat, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        @(negedge clk);
        a_i = av;
        p_i = pv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            to = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
            if (lat >= 200) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    // Accept the pending result after `hold` stalled cycles.
    task automatic ack(input int hold);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (f !== '0) begin errors++; $display("FAIL rst_f got %h exp 0", f); end
        checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL rst_div0 got %b exp 0", div0); end
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        vec_t da[4], df[4];
        logic signed [W-1:0] dp[4];
        bit dd[4];
        int lat;
        bit to;
        da[0] = mk(256, -512, 100); dp[0] = 16'sd512;  df[0] = mk(128, -256, 50);  dd[0] = 1'b0;
        da[1] = mk(256, -512, 100); dp[1] = -16'sd512; df[1] = mk(-128, 256, -50); dd[1] = 1'b0;
        da[2] = mk(5, -7, 9);       dp[2] = 16'sd0;    df[2] = mk(0, 0, 0);        dd[2] = 1'b1;
        da[3] = mk(1, -1, 0);       dp[3] = 16'sd1;    df[3] = mk(127, -128, 0);   dd[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_wait(da[k], dp[k], lat, to);
            checks++; if (to) begin errors++; $display("FAIL dir%0d_timeout got timeout exp out_valid", k); end
            checks++; if (lat != LAT) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", k, lat, LAT); end
            checks++; if (f !== df[k]) begin errors++; $display("FAIL dir%0d_f got %h exp %h", k, f, df[k]); end
            checks++; if (div0 !== dd[k]) begin errors++; $display("FAIL dir%0d_div0 got %b exp %b", k, div0, dd[k]); end
            ack(0);
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL dir%0d_release got out_valid=%b in_ready=%b exp 0/1", k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        vec_t exp_f;
        int lat;
        bit to;
        exp_f = mk(128, -256, 50);
        send_wait(mk(256, -512, 100), 16'sd512, lat, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got timeout exp out_valid"); end
        for (int c = 0; c < 10; c++) begin
            a_i = mk(c + 7, 3, -3);
            p_i = 16'sd2;
            in_valid = 1'b1;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || f !== exp_f || div0 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got ov=%b ir=%b f=%h d0=%b exp 1/0/%h/0", c, out_valid, in_ready, f, div0, exp_f);
            end
        end
        in_valid = 1'b0;
        ack(0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || f !== exp_f) begin
            errors++; $display("FAIL bp_release got ov=%b ir=%b f=%h exp 0/1/%h", out_valid, in_ready, f, exp_f);
        end
        // The vector offered while busy must not have been taken.
        repeat (30) @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ignored got ov=%b ir=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_midreset();
        vec_t av, ef;
        logic ed;
        int lat;
        bit to;
        av = mk(1000, 2000, -3000);
        model(av, 16'sd3000, ef, ed);
        send_wait(av, 16'sd3000, lat, to);
        checks++; if (f !== ef || to) begin errors++; $display("FAIL mr_pre got f=%h to=%b exp %h/0", f, to, ef); end
        ack(0);
        @(negedge clk);
        a_i = mk(256, -512, 100);
        p_i = 16'sd512;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_l = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || f !== '0) begin
            errors++; $display("FAIL mr_abort got ov=%b ir=%b f=%h exp 0/1/0", out_valid, in_ready, f);
        end
        @(negedge clk);
        reset_l = 1'b1;
        repeat (25) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_no_partial got ov=%b exp 0", out_valid); end
        av = mk(-700, 333, 12345);
        model(av, -16'sd700, ef, ed);
        send_wait(av, -16'sd700, lat, to);
        checks++; if (to || lat != LAT) begin errors++; $display("FAIL mr_next_lat got %0d to=%b exp %0d", lat, to, LAT); end
        checks++; if (f !== ef || div0 !== ed) begin
            errors++; $display("FAIL mr_next_f got %h/%b exp %h/%b", f, div0, ef, ed);
        end
        ack(0);
    endtask

    task automatic test_random();
        vec_t av, ef;
        logic ed;
        logic signed [W-1:0] pv;
        int lat, sel, best, m;
        bit to;
        for (int k = 0; k < 25; k++) begin
            for (int i = 1; i <= N; i++) av[i] = W'($urandom);
            sel = $urandom_range(0, 5);
            if (sel == 0) begin
                pv = 16'sd0;
            end else if (sel == 1) begin
                pv = -16'sd32768;
            end else if (sel == 2) begin
                pv = W'($urandom_range(1, 8));
                if ($urandom_range(0, 1) == 1) pv = -pv;
            end else begin
                best = 1;
                for (int i = 1; i <= N; i++) begin
                    m = int'($signed(av[i]));
                    if (m < 0) m = -m;
                    if (m >= best) begin best = m; pv = av[i]; end
                end
                if (best == 1) pv = 16'sd1;
            end
            model(av, pv, ef, ed);
            send_wait(av, pv, lat, to);
            checks++; if (to || lat != LAT) begin errors++; $display("FAIL rnd%0d_lat got %0d to=%b exp %0d", k, lat, to, LAT); end
            checks++; if (f !== ef) begin errors++; $display("FAIL rnd%0d_f a=%h p=%0d got %h exp %h", k, av, pv, f, ef); end
            checks++; if (div0 !== ed) begin errors++; $display("FAIL rnd%0d_div0 got %b exp %b", k, div0, ed); end
            ack($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
